// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response and memory-side bus signals of mem_port_arbiter.
// master: arbiter view. slave: environment view (core plus memory).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;

  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic [1:0]        ls_size;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_read_valid;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_write_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              bus_err;

  modport master (
    input  fetch_req, fetch_addr, ls_req, ls_addr, ls_size, ls_wdata, mem_ack, mem_rdata,
    output fetch_valid, fetch_data, ls_read_valid, ls_rdata, ls_write_ready,
           mem_req, mem_we, mem_addr, mem_size, mem_wdata, bus_err
  );

  modport slave (
    output fetch_req, fetch_addr, ls_req, ls_addr, ls_size, ls_wdata, mem_ack, mem_rdata,
    input  fetch_valid, fetch_data, ls_read_valid, ls_rdata, ls_write_ready,
           mem_req, mem_we, mem_addr, mem_size, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store (LS has priority).
// Optional bus timeout with abort and bus_err pulse when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic             CLK,
  input logic             reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH_WAIT, LS_WAIT, RESP} state_t;

  localparam logic [1:0] SIZE_LOAD = 2'b11;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_port_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t state;
  logic   stale;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state              <= IDLE;
      stale              <= 1'b0;
      bus.fetch_valid    <= 1'b0;
      bus.fetch_data     <= DATA_W'(0);
      bus.ls_read_valid  <= 1'b0;
      bus.ls_rdata       <= DATA_W'(0);
      bus.ls_write_ready <= 1'b0;
      bus.mem_req        <= 1'b0;
      bus.mem_we         <= 1'b0;
      bus.mem_addr       <= ADDR_W'(0);
      bus.mem_size       <= 2'b00;
      bus.mem_wdata      <= DATA_W'(0);
      bus.bus_err        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt            <= CNT_W'(0);
`endif
    end else begin
      // Response strobes are single-cycle pulses.
      bus.fetch_valid    <= 1'b0;
      bus.ls_read_valid  <= 1'b0;
      bus.ls_write_ready <= 1'b0;
      bus.bus_err        <= 1'b0;

      case (state)
        IDLE: begin
          stale <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          tmo_cnt <= CNT_W'(0);
`endif
          if (bus.ls_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= (bus.ls_size != SIZE_LOAD);
            bus.mem_addr  <= bus.ls_addr;
            bus.mem_size  <= bus.ls_size;
            bus.mem_wdata <= (bus.ls_size != SIZE_LOAD) ? bus.ls_wdata : DATA_W'(0);
            state         <= LS_WAIT;
          end else if (bus.fetch_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.fetch_addr;
            bus.mem_size  <= SIZE_LOAD;
            bus.mem_wdata <= DATA_W'(0);
            state         <= FETCH_WAIT;
          end
        end

        FETCH_WAIT, LS_WAIT: begin
          // A fetch withdrawn at any point of its wait is stale, including the ack cycle.
          if (state == FETCH_WAIT && !bus.fetch_req) stale <= 1'b1;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= RESP;
            if (state == LS_WAIT) begin
              if (bus.mem_we) begin
                bus.ls_write_ready <= 1'b1;
              end else begin
                bus.ls_read_valid <= 1'b1;
                bus.ls_rdata      <= bus.mem_rdata;
              end
            end else if (!stale && bus.fetch_req) begin
              bus.fetch_valid <= 1'b1;
              bus.fetch_data  <= bus.mem_rdata;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.mem_req <= 1'b0;
            bus.bus_err <= 1'b1;
            state       <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end

        RESP: begin
          stale <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized transaction bench for mem_port_arbiter with a transaction-level model.
// Define ARB_TIMEOUT_EN for both files to include the timeout abort scenario.
module tb_mem_port_arbiter;

  localparam int unsigned TMO = 16;

  logic CLK = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] exp_fetch_data;
  logic [31:0] exp_ls_rdata;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_fetch_valid"}, 32'(bus.fetch_valid), 32'd0);
    chk({tag, "_ls_read_valid"}, 32'(bus.ls_read_valid), 32'd0);
    chk({tag, "_ls_write_ready"}, 32'(bus.ls_write_ready), 32'd0);
    chk({tag, "_bus_err"}, 32'(bus.bus_err), 32'd0);
    chk({tag, "_fetch_data"}, bus.fetch_data, exp_fetch_data);
    chk({tag, "_ls_rdata"}, bus.ls_rdata, exp_ls_rdata);
  endtask

  // One granted transaction: request at IDLE, lat wait cycles, ack, response, RESP cycle.
  task automatic do_txn(input bit freq, input logic [31:0] faddr, input bit lreq,
                        input logic [1:0] lsize, input logic [31:0] laddr,
                        input logic [31:0] lwdata, input int lat,
                        input logic [31:0] rdata, input bit drop_fetch);
    bit          is_ls, is_store, stale;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    is_ls    = lreq;
    is_store = lreq && (lsize != 2'b11);
    e_addr   = is_ls ? laddr : faddr;
    e_size   = is_ls ? lsize : 2'b11;
    e_wdata  = is_store ? lwdata : 32'd0;
    stale    = 1'b0;

    bus.fetch_req = freq;  bus.fetch_addr = faddr;
    bus.ls_req    = lreq;  bus.ls_addr    = laddr;
    bus.ls_size   = lsize; bus.ls_wdata   = lwdata;
    tick();
    chk("grant_req", 32'(bus.mem_req), 32'd1);
    chk("grant_addr", bus.mem_addr, e_addr);
    chk("grant_we", 32'(bus.mem_we), 32'(is_store));
    chk("grant_size", 32'(bus.mem_size), 32'(e_size));
    chk("grant_wdata", bus.mem_wdata, e_wdata);
    chk_quiet("grant");

    if (!is_ls && drop_fetch) begin
      bus.fetch_req = 1'b0;
      stale = 1'b1;
    end
    bus.fetch_addr = $urandom;
    bus.ls_addr    = $urandom;
    bus.ls_wdata   = $urandom;

    repeat (lat) begin
      tick();
      chk("hold_req", 32'(bus.mem_req), 32'd1);
      chk("hold_addr", bus.mem_addr, e_addr);
      chk("hold_size", 32'(bus.mem_size), 32'(e_size));
      chk("hold_wdata", bus.mem_wdata, e_wdata);
      chk_quiet("hold");
    end

    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    if (is_ls && !is_store) exp_ls_rdata = rdata;
    if (!is_ls && !stale) exp_fetch_data = rdata;
    chk("ack_req", 32'(bus.mem_req), 32'd0);
    chk("ack_fetch_valid", 32'(bus.fetch_valid), 32'(!is_ls && !stale));
    chk("ack_fetch_data", bus.fetch_data, exp_fetch_data);
    chk("ack_ls_read_valid", 32'(bus.ls_read_valid), 32'(is_ls && !is_store));
    chk("ack_ls_rdata", bus.ls_rdata, exp_ls_rdata);
    chk("ack_ls_write_ready", 32'(bus.ls_write_ready), 32'(is_store));
    chk("ack_bus_err", 32'(bus.bus_err), 32'd0);

    // Owner releases; a losing fetch stays pending. A stray ack in RESP must be ignored.
    if (is_ls) bus.ls_req = 1'b0;
    else       bus.fetch_req = 1'b0;
    bus.mem_rdata = $urandom;
    bus.mem_ack   = 1'($urandom_range(0, 1));
    tick();
    bus.mem_ack = 1'b0;
    chk("resp_req", 32'(bus.mem_req), 32'd0);
    chk_quiet("resp");
  endtask

  initial begin
    exp_fetch_data = 32'd0;
    exp_ls_rdata   = 32'd0;
    reset          = 1'b1;
    bus.fetch_req  = 1'b0; bus.fetch_addr = 32'd0;
    bus.ls_req     = 1'b0; bus.ls_addr    = 32'd0;
    bus.ls_size    = 2'b00; bus.ls_wdata  = 32'd0;
    bus.mem_ack    = 1'b0; bus.mem_rdata  = 32'd0;
    tick();
    tick();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_size", 32'(bus.mem_size), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk_quiet("rst");
    reset = 1'b0;

    // Ack while idle with nothing requested
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    chk("idle_ack_req", 32'(bus.mem_req), 32'd0);
    chk_quiet("idle_ack");

    // Plain fetch
    do_txn(1'b1, 32'h1000, 1'b0, 2'b11, 32'h0, 32'h0, 2, 32'h00500093, 1'b0);

    // Simultaneous requests: load wins, fetch follows two cycles after the ack
    do_txn(1'b1, 32'h1000, 1'b1, 2'b11, 32'h2004, 32'h0, 1, 32'hDEADBEEF, 1'b0);
    do_txn(1'b1, 32'h1000, 1'b0, 2'b11, 32'h0, 32'h0, 0, 32'h00A00113, 1'b0);

    // Byte store
    do_txn(1'b0, 32'h0, 1'b1, 2'b00, 32'h3001, 32'h000000AB, 2, 32'h55555555, 1'b0);

    // Withdrawn fetch: completes on the bus, response suppressed; next fetch granted at M+2
    do_txn(1'b1, 32'h1000, 1'b0, 2'b11, 32'h0, 32'h0, 1, 32'h12345678, 1'b1);
    do_txn(1'b1, 32'h1004, 1'b0, 2'b11, 32'h0, 32'h0, 0, 32'h00000013, 1'b0);

    // Reset in the middle of a load wait; the late ack must be ignored
    bus.ls_req = 1'b1; bus.ls_size = 2'b11; bus.ls_addr = 32'h4000;
    tick();
    chk("mid_grant_req", 32'(bus.mem_req), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.ls_req = 1'b0;
    exp_fetch_data = 32'd0;
    exp_ls_rdata   = 32'd0;
    chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
    chk_quiet("mid_rst");
    tick();
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAADF00D;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("late_ack_req", 32'(bus.mem_req), 32'd0);
    chk_quiet("late_ack");

`ifdef ARB_TIMEOUT_EN
    // No ack: abort after TMO wait cycles with a bus_err pulse and no fetch response
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h5000;
    tick();
    chk("tmo_grant_req", 32'(bus.mem_req), 32'd1);
    repeat (TMO - 1) begin
      tick();
      chk("tmo_wait_req", 32'(bus.mem_req), 32'd1);
      chk("tmo_wait_err", 32'(bus.bus_err), 32'd0);
    end
    tick();
    bus.fetch_req = 1'b0;
    chk("tmo_err", 32'(bus.bus_err), 32'd1);
    chk("tmo_req", 32'(bus.mem_req), 32'd0);
    chk("tmo_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("tmo_fetch_data", bus.fetch_data, exp_fetch_data);
    tick();
    chk_quiet("tmo_resp");
`endif

    // Randomized traffic
    for (int n = 0; n < 25; n++) begin
      bit          fr, lr, drop;
      logic [31:0] fa;
      fr   = 1'($urandom_range(0, 1));
      lr   = 1'($urandom_range(0, 1));
      if (!fr && !lr) lr = 1'b1;
      fa   = $urandom & 32'hFFFF_FFFC;
      drop = !lr && ($urandom_range(0, 2) == 0);
      do_txn(fr, fa, lr, 2'($urandom_range(0, 3)), $urandom, $urandom,
             int'($urandom_range(0, 6)), $urandom, drop);
      if (fr && lr)
        do_txn(1'b1, fa, 1'b0, 2'b11, 32'h0, 32'h0, int'($urandom_range(0, 6)),
               $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch and the load/store path of the core.
- Sits between core (fetch_enable/PCfetch/fetch_valid, memory_en_out/mem_addr/store_size/mem_write_data/mem_read_data_valid/mem_write_ready) and the memory/bus interface.
- Grants one transaction at a time, sequences it to completion, and routes the response back to the owner. Load/store has fixed priority over fetch.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- TIMEOUT_CYCLES, 255, cycles without mem_ack before abort (used only with ARB_TIMEOUT_EN)

Ports:
- CLK  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch request (core fetch_enable)
- fetch_addr  in  ADDR_W  instruction address (PCfetch)
- fetch_valid  out  1  one-cycle pulse: fetch_data valid
- fetch_data  out  DATA_W  fetched instruction
- ls_req  in  1  load/store request (memory_en_out)
- ls_addr  in  ADDR_W  data address
- ls_size  in  2  00 byte, 01 half, 10 word store; 11 = load
- ls_wdata  in  DATA_W  store data
- ls_read_valid  out  1  one-cycle pulse: ls_rdata valid (load done)
- ls_rdata  out  DATA_W  load data
- ls_write_ready  out  1  one-cycle pulse: store done
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  memory address
- mem_size  out  2  copy of ls_size for LS, 11 for fetch
- mem_wdata  out  DATA_W  write data (0 for reads)
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- bus_err  out  1  one-cycle timeout pulse (ARB_TIMEOUT_EN only, else tied 0)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All outputs registered.
- Reset values: all outputs 0; state IDLE; stale flag 0; timeout counter 0.
- FSM states: IDLE, FETCH_WAIT, LS_WAIT, RESP.
- IDLE:
  - if ls_req=1, latch ls_addr/ls_size/ls_wdata, go LS_WAIT.
  - else if fetch_req=1, latch fetch_addr, go FETCH_WAIT.
  - else stay.
  - ls_req and fetch_req in the same cycle: LS wins; fetch stays pending.
- Grant latency: request sampled in IDLE at edge N; mem_req=1 with latched addr/we/size/wdata from N+1.
- mem_req, mem_addr, mem_we, mem_size and mem_wdata stay stable until the cycle mem_ack=1.
- mem_we = 1 iff the LS grant has ls_size != 11.
- mem_wdata = ls_wdata for stores, 0 otherwise.
- Ack: mem_ack in *_WAIT at edge M:
  - mem_req drops at M+1; state RESP for one cycle (M+1).
  - Exactly one response pulse at M+1: fetch_valid+fetch_data, ls_read_valid+ls_rdata (load), or ls_write_ready (store).
  - Data outputs hold the last captured value afterwards.
- RESP: no sampling of requests; state IDLE at M+2.
  - A requester must drop or replace its req by M+2, otherwise it is regranted.
  - Minimum spacing between grants: 3 cycles.
- Fetch withdrawal: fetch_req=0 in any FETCH_WAIT cycle (branch/flush) sets stale.
  - Transaction still completes on the bus; at ack fetch_valid is suppressed and fetch_data is not updated.
  - stale clears in RESP.
- ls_req must not be withdrawn during LS_WAIT; if it drops, the transaction completes and the response is still pulsed.
- mem_ack outside *_WAIT (IDLE/RESP) is ignored.
- Reset mid-transaction: next edge IDLE, mem_req=0, no response pulse; a late mem_ack is ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With the macro:
  - counter cleared on entry to *_WAIT and incremented each WAIT cycle without mem_ack.
  - On reaching TIMEOUT_CYCLES: mem_req drops, bus_err pulses one cycle, state RESP.
  - No fetch_valid/ls_read_valid/ls_write_ready pulse and no data update.
  - mem_ack arriving in the same cycle as the count reaching the limit wins as a normal completion.
- Without the macro: no counter; bus_err constant 0; WAIT states hold indefinitely.

Test Plan:
- fetch_req=1, fetch_addr=0x1000; mem_ack after 3 cycles, mem_rdata=0x00500093 -> mem_req=1 at N+1, mem_we=0, mem_size=11; fetch_valid pulses once with 0x00500093.
- fetch_req and ls_req(ls_size=11, ls_addr=0x2004) together -> first grant mem_addr=0x2004; ls_read_valid pulses with ack data 0xDEADBEEF; fetch of 0x1000 granted at IDLE two cycles after ack.
- ls_req, ls_size=00, ls_addr=0x3001, ls_wdata=0x000000AB -> mem_we=1, mem_size=00, mem_wdata=0xAB; ls_write_ready pulses; ls_read_valid stays 0.
- fetch 0x1000 granted, fetch_req dropped 1 cycle later, ack with 0x12345678 -> no fetch_valid, fetch_data unchanged; FSM IDLE two cycles after ack.
- reset=1 during LS_WAIT, mem_ack 2 cycles later -> mem_req=0 after reset edge; no response pulse; late ack ignored.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, fetch granted, no ack -> bus_err pulses after 16 WAIT cycles, mem_req drops, no fetch_valid; next request granted normally.
